// File: rtl/mat_unit.sv
// mat_unit: N x N weight-stationary systolic multiply-accumulate array.
// Row i takes skewed lane data_in[i]; operands shift right one column per
// cycle, partial sums flow down, and data_out[j] is the registered bottom
// partial sum of column j. Weights are captured from the operand path
// during a load phase, one row per step once weight_progress reaches N.
// Build option: define MATUNIT_SATURATE_EN to make every multiply and every
// accumulate saturate to the signed DATA_WIDTH range instead of wrapping.
module mat_unit #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               load_weight,
  input  logic [$clog2(2*N)-1:0]             weight_progress,
  input  logic [N-1:0][DATA_WIDTH-1:0]       data_in,
  output logic [N-1:0][DATA_WIDTH-1:0]       data_out
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = $clog2(2*N);

`ifdef MATUNIT_SATURATE_EN
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
`endif

  // Signed multiply of two DW-bit operands, result DW bits.
  function automatic logic [DW-1:0] mul_f(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
`ifdef MATUNIT_SATURATE_EN
    logic signed [2*DW-1:0] p;
    p = $signed(a) * $signed(b);
    // Product fits only if the upper DW+1 bits are a pure sign extension.
    if (p[2*DW-1:DW-1] != {(DW+1){p[2*DW-1]}})
      return p[2*DW-1] ? SMIN : SMAX;
    return p[DW-1:0];
`else
    // Low DW bits of a product are the same for signed and unsigned operands.
    return a * b;
`endif
  endfunction

  // Signed add of two DW-bit operands, result DW bits.
  function automatic logic [DW-1:0] add_f(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
`ifdef MATUNIT_SATURATE_EN
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      return s[DW] ? SMIN : SMAX;
    return s[DW-1:0];
`else
    return a + b;
`endif
  endfunction

  logic [DW-1:0] a_q    [N][N];
  logic [DW-1:0] a_d    [N][N];
  logic [DW-1:0] w_q    [N][N];
  logic [DW-1:0] w_d    [N][N];
  logic [DW-1:0] psum_q [N][N];
  logic [DW-1:0] psum_d [N][N];
  logic [DW-1:0] a_in   [N][N];
  logic [DW-1:0] ps_in  [N][N];

  // Operand and partial-sum inputs seen by each PE.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i][0] = data_in[i];
      for (int j = 1; j < N; j++) begin
        a_in[i][j] = a_q[i][j-1];
      end
    end
    for (int j = 0; j < N; j++) begin
      ps_in[0][j] = '0;
      for (int i = 1; i < N; i++) begin
        ps_in[i][j] = psum_q[i-1][j];
      end
    end
  end

  // Next state: operand shift, MAC, and row-wise weight capture.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_d[i][j]    = a_in[i][j];
        // The MAC always uses the weight held before this edge; a freshly
        // captured weight takes effect on the following cycle.
        psum_d[i][j] = add_f(ps_in[i][j], mul_f(w_q[i][j], a_in[i][j]));
        w_d[i][j]    = w_q[i][j];
        if (load_weight && (weight_progress == PW'(N + i)))
          w_d[i][j] = a_in[i][j];
      end
    end
  end

  // Array state registers; reset clears weights and all in-flight data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]    <= '0;
          w_q[i][j]    <= '0;
          psum_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_q[i][j]    <= a_d[i][j];
          w_q[i][j]    <= w_d[i][j];
          psum_q[i][j] <= psum_d[i][j];
        end
      end
    end
  end

  // Column results are the bottom-row partial sums.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      data_out[j] = psum_q[N-1][j];
    end
  end

endmodule

// File: tb/tb_mat_unit.sv
// Directed testbench for mat_unit (N=4, DATA_WIDTH=32).
// Cycle c of each run() call is the cycle in which lane 0 of the first vector
// is applied; cap[c][j] holds data_out[j] observed during cycle c.
module tb_mat_unit;
  localparam int N  = 4;
  localparam int DW = 32;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   load_weight;
  logic [2:0]             weight_progress;
  logic [N-1:0][DW-1:0]   data_in;
  logic [N-1:0][DW-1:0]   data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] vecs [0:3][0:N-1];
  logic [DW-1:0] wl   [0:N-1][0:N-1];
  logic [DW-1:0] cap  [0:23][0:N-1];
  bit            wp_noise = 1'b0;

  mat_unit #(.N(N), .DATA_WIDTH(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .load_weight    (load_weight),
    .weight_progress(weight_progress),
    .data_in        (data_in),
    .data_out       (data_out)
  );

  always #5 clock = ~clock;

  // Drive ncyc cycles: nvec skewed vectors from vecs starting at cycle 0, and
  // optionally a full weight load of wl starting at cycle load_at.
  task automatic run(input int nvec, input int load_at, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic lw;
      for (int i = 0; i < N; i++) begin
        int k;
        int lc;
        logic [DW-1:0] d;
        k  = c - i;
        lc = c - load_at;
        d  = '0;
        if (k >= 0 && k < nvec) d = vecs[k][i];
        if (load_at >= 0 && lc >= i + 1 && lc <= N + i) d = wl[i][N + i - lc];
        data_in[i] = d;
      end
      lw = (load_at >= 0) && (c >= load_at) && (c < load_at + 2*N);
      load_weight = lw;
      if (lw)            weight_progress = 3'(c - load_at);
      else if (wp_noise) weight_progress = 3'(c % 8);
      else               weight_progress = '0;
      @(posedge clock); #1;
      for (int j = 0; j < N; j++) cap[c+1][j] = data_out[j];
    end
    data_in = '0;
    load_weight = 1'b0;
    weight_progress = '0;
  endtask

  task automatic load_w();
    run(0, 0, 2*N);
    run(0, -1, 2*N);
  endtask

  task automatic set_w_ones();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wl[i][j] = 32'd1;
  endtask

  task automatic set_w_ident();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wl[i][j] = (i == j) ? 32'd1 : 32'd0;
  endtask

  task automatic set_vec(input int k, input int e0, input int e1, input int e2, input int e3);
    vecs[k][0] = e0; vecs[k][1] = e1; vecs[k][2] = e2; vecs[k][3] = e3;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_weight = 1'b0;
    weight_progress = '0;
    data_in = '0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %h expected 0", data_out);
    end
    reset = 1'b0;
    set_vec(0, 5, 5, 5, 5);
    run(1, -1, 10);
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (cap[N+j][j] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_zero_w col%0d: got %0d expected 0", j, cap[N+j][j]);
      end
    end
  endtask

  task automatic test_ones_fives();
    set_w_ones();
    load_w();
    set_vec(0, 5, 5, 5, 5);
    run(1, -1, 10);
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (cap[N+j][j] !== 32'd20) begin
        n_fail++;
        $display("FAIL fives col%0d: got %0d expected 20", j, cap[N+j][j]);
      end
      n_checks++;
      if (cap[N+j-1][j] !== 32'd0) begin
        n_fail++;
        $display("FAIL fives_early col%0d: got %0d expected 0", j, cap[N+j-1][j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_seq [0:3];
    exp_seq = '{4, 0, 10, 0};
    set_vec(0, 1, 1, 1, 1);
    set_vec(1, 0, 0, 0, 0);
    set_vec(2, 1, 2, 3, 4);
    run(3, -1, 14);
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < 4; k++) begin
        logic [DW-1:0] e;
        e = exp_seq[k];
        n_checks++;
        if (cap[N+j+k][j] !== e) begin
          n_fail++;
          $display("FAIL b2b col%0d slot%0d: got %0d expected %0d", j, k, cap[N+j+k][j], e);
        end
      end
    end
  endtask

  task automatic test_identity_overlap();
    set_w_ident();
    load_w();
    set_vec(0, 1, 2, 3, 4);
    set_w_ones();
    // New all-ones rows start loading one cycle after the vector enters.
    run(1, 1, 14);
    for (int j = 0; j < N; j++) begin
      logic [DW-1:0] e;
      e = j + 1;
      n_checks++;
      if (cap[N+j][j] !== e) begin
        n_fail++;
        $display("FAIL ident col%0d: got %0d expected %0d", j, cap[N+j][j], e);
      end
    end
    run(1, -1, 10);
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (cap[N+j][j] !== 32'd10) begin
        n_fail++;
        $display("FAIL reloaded col%0d: got %0d expected 10", j, cap[N+j][j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_vec(0, 5, 5, 5, 5);
    run(1, -1, 6);
    n_checks++;
    if (cap[5][1] !== 32'd20) begin
      n_fail++;
      $display("FAIL pre_reset col1: got %0d expected 20", cap[5][1]);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (data_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", data_out);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    run(1, -1, 10);
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (cap[N+j][j] !== 32'd0) begin
        n_fail++;
        $display("FAIL post_reset_w col%0d: got %0d expected 0", j, cap[N+j][j]);
      end
    end
    set_w_ones();
    load_w();
    run(1, -1, 10);
    for (int j = 0; j < N; j++) begin
      n_checks++;
      if (cap[N+j][j] !== 32'd20) begin
        n_fail++;
        $display("FAIL post_reset_load col%0d: got %0d expected 20", j, cap[N+j][j]);
      end
    end
  endtask

  task automatic test_no_load();
    int wm  [0:3][0:3];
    int exp_nl [0:2][0:3];
    wm     = '{'{1, 2, 0, 0}, '{0, 1, 0, 3}, '{2, 0, 1, 0}, '{0, 0, -1, 1}};
    exp_nl = '{'{7, 4, -1, 10}, '{19, 16, -1, 26}, '{31, 28, -1, 42}};
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wl[i][j] = wm[i][j];
    load_w();
    set_vec(0, 1, 2, 3, 4);
    set_vec(1, 5, 6, 7, 8);
    set_vec(2, 9, 10, 11, 12);
    wp_noise = 1'b1;
    run(3, -1, 14);
    wp_noise = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] e;
        e = exp_nl[k][j];
        n_checks++;
        if (cap[N+j+k][j] !== e) begin
          n_fail++;
          $display("FAIL noload v%0d col%0d: got %0d expected %0d", k, j, $signed(cap[N+j+k][j]), $signed(e));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] e_all2;
    logic [DW-1:0] e_one2;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wl[i][j] = (j == 0) ? 32'h4000_0000 : 32'd0;
    load_w();
    set_vec(0, 2, 2, 2, 2);
    set_vec(1, 2, 0, 0, 0);
    run(2, -1, 12);
`ifdef MATUNIT_SATURATE_EN
    e_all2 = 32'h7FFF_FFFF;
    e_one2 = 32'h7FFF_FFFF;
`else
    e_all2 = 32'h0000_0000;
    e_one2 = 32'h8000_0000;
`endif
    n_checks++;
    if (cap[N][0] !== e_all2) begin
      n_fail++;
      $display("FAIL ovf_all2: got %h expected %h", cap[N][0], e_all2);
    end
    n_checks++;
    if (cap[N+1][0] !== e_one2) begin
      n_fail++;
      $display("FAIL ovf_one2: got %h expected %h", cap[N+1][0], e_one2);
    end
    n_checks++;
    if (cap[N+1][1] !== 32'd0) begin
      n_fail++;
      $display("FAIL ovf_col1: got %h expected 0", cap[N+1][1]);
    end
  endtask

  initial begin
    reset = 1'b1;
    load_weight = 1'b0;
    weight_progress = '0;
    data_in = '0;
    test_reset();
    test_ones_fives();
    test_back_to_back();
    test_identity_overlap();
    test_reset_mid();
    test_no_load();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
